// File: rtl/coin_sensor_driver.sv
// Coin-insertion emulator: turns a command into the sensor_1/2/3 waveform, then reports motor response or timeout.
// Latency: first sensor cycle one clock after acceptance; cmd_ready only in IDLE, so commands wait while busy.
module coin_sensor_driver #(
    parameter int AMT_W       = 5,
    parameter int LEAD_CYC    = 1,
    parameter int TRAIL_CYC   = 2,
    parameter int RSP_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic             cmd_cancel,
    output logic             sensor_1,
    output logic             sensor_2,
    output logic             sensor_3,
    input  logic             motor_1,
    input  logic             motor_2,
    input  logic             motor_3,
    output logic             rsp_valid,
    output logic [2:0]       rsp_motor,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int UNIT_MAX = (1 << (AMT_W - 1)) - 1;
    localparam int MAX_A    = (LEAD_CYC > TRAIL_CYC) ? LEAD_CYC : TRAIL_CYC;
    localparam int MAX_B    = (RSP_TIMEOUT > UNIT_MAX) ? RSP_TIMEOUT : UNIT_MAX;
    localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_UNIT, S_HALF, S_CANCEL, S_TRAIL, S_WAIT, S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AMT_W-2:0]   units_q, units_d;
    logic               half_q, half_d;
    logic               cancel_q, cancel_d;
    logic [2:0]         acc_q, acc_d;
    logic [2:0]         sens_q;
    logic               cmd_ready_q;
    logic               busy_q;
    logic               rsp_valid_q;
    logic [2:0]         rsp_motor_q;
    logic               rsp_timeout_q;
    logic [2:0]         motors;
    logic               accept;

    assign motors = {motor_3, motor_2, motor_1};
    assign accept = cmd_valid && cmd_ready_q;

    // Sensor vector {s3,s2,s1} produced while sitting in a given state.
    function automatic logic [2:0] sens_of(input state_t s);
        case (s)
            S_UNIT:   sens_of = 3'b011;
            S_HALF:   sens_of = 3'b001;
            S_CANCEL: sens_of = 3'b100;
            default:  sens_of = 3'b000;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        units_d  = units_q;
        half_d   = half_q;
        cancel_d = cancel_q;
        acc_d    = acc_q;

        if (state_q inside {S_LEAD, S_UNIT, S_HALF, S_CANCEL, S_TRAIL, S_WAIT})
            acc_d = acc_q | motors;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    units_d  = cmd_amount[AMT_W-1:1];
                    half_d   = cmd_amount[0];
                    cancel_d = cmd_cancel;
                    acc_d    = 3'b000;
                    state_d  = S_LEAD;
                end
            end
            S_LEAD: begin
                if (cnt_q == CNT_W'(LEAD_CYC - 1)) begin
                    if (cancel_q)
                        state_d = S_CANCEL;
                    else if (units_q != '0)
                        state_d = S_UNIT;
                    else if (half_q)
                        state_d = S_HALF;
                    else
                        state_d = S_TRAIL;
                end
            end
            S_UNIT: begin
                if (cnt_q + CNT_W'(1) == CNT_W'(units_q))
                    state_d = half_q ? S_HALF : S_TRAIL;
            end
            S_HALF, S_CANCEL: state_d = S_TRAIL;
            S_TRAIL: begin
                if (cnt_q == CNT_W'(TRAIL_CYC - 1))
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                // A motor pulse counts as finished only once it has been seen and has dropped.
                if (((acc_q != 3'b000) && (motors == 3'b000)) ||
                    (cnt_q == CNT_W'(RSP_TIMEOUT - 1)))
                    state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q || state_q == S_IDLE)
            cnt_d = '0;
    end

    // Outputs are registered decodes of the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            units_q       <= '0;
            half_q        <= 1'b0;
            cancel_q      <= 1'b0;
            acc_q         <= 3'b000;
            sens_q        <= 3'b000;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_motor_q   <= 3'b000;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            units_q     <= units_d;
            half_q      <= half_d;
            cancel_q    <= cancel_d;
            acc_q       <= acc_d;
            sens_q      <= sens_of(state_d);
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            if (state_d == S_RESP) begin
                rsp_motor_q   <= acc_d;
                rsp_timeout_q <= (acc_d == 3'b000);
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign sensor_1    = sens_q[0];
    assign sensor_2    = sens_q[1];
    assign sensor_3    = sens_q[2];
    assign rsp_valid   = rsp_valid_q;
    assign rsp_motor   = rsp_motor_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_coin_sensor_driver.sv
// Directed bench for coin_sensor_driver: sensor waveforms, motor capture, timeout, back-to-back and mid-transaction reset.
module tb_coin_sensor_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_amount = '0;
    logic       cmd_cancel = 1'b0;
    logic       sensor_1, sensor_2, sensor_3;
    logic       motor_1 = 1'b0, motor_2 = 1'b0, motor_3 = 1'b0;
    logic       rsp_valid;
    logic [2:0] rsp_motor;
    logic       rsp_timeout;
    logic       busy;

    int errors = 0;
    int checks = 0;

    coin_sensor_driver #(
        .AMT_W(5), .LEAD_CYC(1), .TRAIL_CYC(2), .RSP_TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_amount(cmd_amount), .cmd_cancel(cmd_cancel),
        .sensor_1(sensor_1), .sensor_2(sensor_2), .sensor_3(sensor_3),
        .motor_1(motor_1), .motor_2(motor_2), .motor_3(motor_3),
        .rsp_valid(rsp_valid), .rsp_motor(rsp_motor),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [4:0] amt, input logic cnc);
        int n;
        cmd_amount = amt;
        cmd_cancel = cnc;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: cmd_ready=%b expected 1 within 50 cycles", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    // Called on the first LEAD cycle; leaves the bench on WAIT_RSP cycle 0.
    task automatic check_seq(input string name, input int n_unit, input int n_half,
                             input int n_cancel);
        logic [2:0] exp_s;
        int total;
        total = 1 + n_unit + n_half + n_cancel + 2;
        for (int i = 0; i < total; i++) begin
            if (i == 0 || i >= total - 2) exp_s = 3'b000;
            else if (n_cancel != 0)       exp_s = 3'b100;
            else if (i <= n_unit)         exp_s = 3'b011;
            else                          exp_s = 3'b001;
            checks++;
            if ({sensor_3, sensor_2, sensor_1} !== exp_s) begin
                errors++;
                $display("FAIL %s_sens cyc%0d: sensors=%b expected %b",
                         name, i, {sensor_3, sensor_2, sensor_1}, exp_s);
            end
            step();
        end
        checks++;
        if ({sensor_3, sensor_2, sensor_1, busy, rsp_valid} !== 5'b00010) begin
            errors++;
            $display("FAIL %s_wait0: sens/busy/rsp=%b expected 00010",
                     name, {sensor_3, sensor_2, sensor_1, busy, rsp_valid});
        end
    endtask

    task automatic check_rsp(input string name, input logic [2:0] exp_m, input logic exp_t);
        checks++;
        if ({rsp_valid, rsp_motor, rsp_timeout} !== {1'b1, exp_m, exp_t}) begin
            errors++;
            $display("FAIL %s_rsp: valid/motor/timeout=%b/%b/%b expected 1/%b/%b",
                     name, rsp_valid, rsp_motor, rsp_timeout, exp_m, exp_t);
        end
        step();
        checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL %s_idle: valid/busy/ready=%b expected 001",
                     name, {rsp_valid, busy, cmd_ready});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({cmd_ready, busy, sensor_3, sensor_2, sensor_1, rsp_valid, rsp_motor, rsp_timeout} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: outputs=%b expected 0000000000",
                     {cmd_ready, busy, sensor_3, sensor_2, sensor_1, rsp_valid, rsp_motor, rsp_timeout});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ready/busy=%b expected 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_amount10();
        send(5'd10, 1'b0);
        check_seq("a10", 5, 0, 0);
        step();
        motor_2 = 1'b1;
        step();
        step();
        motor_2 = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL a10_early: rsp_valid=%b expected 0", rsp_valid);
        end
        step();
        check_rsp("a10", 3'b010, 1'b0);
    endtask

    task automatic test_amount11();
        send(5'd11, 1'b0);
        check_seq("a11", 5, 1, 0);
        motor_2 = 1'b1;
        step();
        motor_3 = 1'b1;
        step();
        motor_2 = 1'b0;
        step();
        motor_3 = 1'b0;
        step();
        check_rsp("a11", 3'b110, 1'b0);
    endtask

    task automatic test_timeout();
        int early;
        send(5'd5, 1'b0);
        check_seq("a5", 2, 1, 0);
        early = 0;
        for (int i = 0; i < 16; i++) begin
            if (rsp_valid !== 1'b0) early++;
            step();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL a5_early: premature rsp_valid cycles=%0d expected 0", early);
        end
        check_rsp("a5", 3'b000, 1'b1);
    endtask

    task automatic test_cancel();
        send(5'd31, 1'b1);
        check_seq("cnc", 0, 0, 1);
        motor_3 = 1'b1;
        step();
        motor_3 = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL cnc_early: rsp_valid=%b expected 0", rsp_valid);
        end
        step();
        check_rsp("cnc", 3'b100, 1'b0);
    endtask

    task automatic test_back_to_back();
        int ready_bad;
        int rsp_idx;
        int n;
        cmd_amount = 5'd2;
        cmd_cancel = 1'b0;
        cmd_valid  = 1'b1;
        step();
        ready_bad = 0;
        rsp_idx   = -1;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready !== 1'b0) ready_bad++;
            if (rsp_valid === 1'b1) begin
                rsp_idx = i;
                break;
            end
            step();
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL b2b_ready_busy: cmd_ready high cycles=%0d expected 0", ready_bad);
        end
        checks++;
        if (rsp_idx != 20) begin
            errors++;
            $display("FAIL b2b_rsp_cycle: rsp at cycle %0d expected 20", rsp_idx);
        end
        step();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_idle: ready/busy=%b expected 10", {cmd_ready, busy});
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, busy, sensor_3, sensor_2, sensor_1} !== 5'b01000) begin
            errors++;
            $display("FAIL b2b_second: ready/busy/sens=%b expected 01000",
                     {cmd_ready, busy, sensor_3, sensor_2, sensor_1});
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_rsp("b2b2", 3'b000, 1'b1);
    endtask

    task automatic test_reset_mid();
        int stray;
        int n;
        send(5'd10, 1'b0);
        step();
        motor_1 = 1'b1;
        step();
        step();
        motor_1 = 1'b0;
        checks++;
        if ({sensor_3, sensor_2, sensor_1} !== 3'b011) begin
            errors++;
            $display("FAIL rst_unit3: sensors=%b expected 011", {sensor_3, sensor_2, sensor_1});
        end
        reset = 1'b1;
        step();
        checks++;
        if ({sensor_3, sensor_2, sensor_1, rsp_valid, busy, cmd_ready} !== 6'b0) begin
            errors++;
            $display("FAIL rst_abort: sens/valid/busy/ready=%b expected 000000",
                     {sensor_3, sensor_2, sensor_1, rsp_valid, busy, cmd_ready});
        end
        reset = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_quiet: stray rsp/busy cycles=%0d expected 0", stray);
        end
        send(5'd4, 1'b0);
        check_seq("a4", 2, 0, 0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL a4_tmo_cycle: rsp after %0d wait cycles expected 16", n);
        end
        check_rsp("a4", 3'b000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_amount10();
        test_amount11();
        test_timeout();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
